// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the single-cycle RV32I core: synchronises the
// trigger button, gates the core through cpu_en and keeps cycle/instret counters.
module cpu_run_ctrl #(
    parameter logic [31:0] HALT_INSTR  = 32'h0000006F,
    parameter int          CNT_W       = 32,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             step_mode,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    output logic             cpu_en,
    output logic             cpu_rst_req,
    output logic [1:0]       state,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    localparam logic [1:0]       CAUSE_NONE = 2'd0;
    localparam logic [1:0]       CAUSE_HALT = 2'd1;
    localparam logic [1:0]       CAUSE_BP   = 2'd2;
    localparam logic [1:0]       CAUSE_STEP = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_e                 state_q, state_d;
    logic [1:0]             cause_q, cause_d;
    logic                   bp_skip_q, bp_skip_d;
    logic [CNT_W-1:0]       cycle_q, cycle_d;
    logic [CNT_W-1:0]       instret_q, instret_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   trig_prev_q, trig_prev_d;
    logic                   trig_evt_q, trig_evt_d;

    logic run_active_s;
    logic halt_hit_s;
    logic bp_hit_s;
    logic cpu_en_s;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    // Trigger synchroniser and rising-edge detector; the event is registered.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], trigger};
        trig_prev_d = sync_q[SYNC_STAGES-1];
        trig_evt_d  = sync_q[SYNC_STAGES-1] & ~trig_prev_q;
    end

    // Stop conditions and core enable; combinational so a halting instruction never executes.
    always_comb begin
        run_active_s = (state_q == ST_RUN) || (state_q == ST_STEP);
        halt_hit_s   = (instr == HALT_INSTR);
        bp_hit_s     = bp_en & (pc == bp_addr) & ~bp_skip_q;
        cpu_en_s     = run_active_s & ~halt_hit_s & ~bp_hit_s;
    end

    // Sequencer next-state, halt cause, breakpoint skip and counters.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        bp_skip_d = bp_skip_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;

        if (cpu_en_s) begin
            bp_skip_d = 1'b0;
            instret_d = sat_inc(instret_q);
        end else begin
            instret_d = instret_q;
        end

        if (run_active_s) begin
            cycle_d = sat_inc(cycle_q);
        end else begin
            cycle_d = cycle_q;
        end

        case (state_q)
            ST_IDLE: begin
                bp_skip_d = 1'b0;
                if (trig_evt_q) begin
                    cycle_d   = CNT_ZERO;
                    instret_d = CNT_ZERO;
                    cause_d   = CAUSE_NONE;
                    state_d   = step_mode ? ST_STEP : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halt_hit_s) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_HALT;
                end else if (bp_hit_s) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_BP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                // Exactly one instruction retires here unless a stop condition pre-empts it.
                if (halt_hit_s) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_HALT;
                end else if (bp_hit_s) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_BP;
                end else begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_STEP;
                end
            end
            ST_HALT: begin
                if (trig_evt_q) begin
                    if (cause_q == CAUSE_HALT) begin
                        state_d   = ST_IDLE;
                        bp_skip_d = 1'b0;
                    end else begin
                        state_d   = step_mode ? ST_STEP : ST_RUN;
                        bp_skip_d = 1'b1;
                        cause_d   = CAUSE_NONE;
                    end
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cause_d   = CAUSE_NONE;
                bp_skip_d = 1'b0;
            end
        endcase
    end

    // State, counter and synchroniser registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cause_q     <= CAUSE_NONE;
            bp_skip_q   <= 1'b0;
            cycle_q     <= CNT_ZERO;
            instret_q   <= CNT_ZERO;
            sync_q      <= {SYNC_STAGES{1'b0}};
            trig_prev_q <= 1'b0;
            trig_evt_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            bp_skip_q   <= bp_skip_d;
            cycle_q     <= cycle_d;
            instret_q   <= instret_d;
            sync_q      <= sync_d;
            trig_prev_q <= trig_prev_d;
            trig_evt_q  <= trig_evt_d;
        end
    end

    assign cpu_en        = cpu_en_s;
    assign cpu_rst_req   = (state_q == ST_IDLE);
    assign state         = state_q;
    assign halt_cause    = cause_q;
    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a tiny PC/imem core model drives pc/instr,
// plus a second instance with 4-bit counters for saturation and async reset.
module tb_cpu_run_ctrl;

    localparam logic [31:0] HALT = 32'h0000006F;
    localparam logic [31:0] ADDI = 32'h00100093;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trigger = 1'b0;
    logic        step_mode = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'h0;
    logic [31:0] pc_m;
    logic [31:0] instr;
    logic        cpu_en, cpu_rst_req;
    logic [1:0]  state, halt_cause;
    logic [31:0] cycle_count, instret_count;

    logic        trig2 = 1'b0;
    logic        cpu_en2, cpu_rst_req2;
    logic [1:0]  state2, halt_cause2;
    logic [3:0]  cycle2, instret2;

    logic [31:0] imem [0:63];
    int          n_vec = 0;
    int          n_err = 0;
    int          run_starts = 0;
    int          en_cnt = 0;
    logic [1:0]  prev_st = 2'd0;

    always #5 clk = ~clk;

    cpu_run_ctrl u_dut (
        .clk(clk), .rst(rst), .trigger(trigger), .step_mode(step_mode),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc_m), .instr(instr),
        .cpu_en(cpu_en), .cpu_rst_req(cpu_rst_req), .state(state),
        .halt_cause(halt_cause), .cycle_count(cycle_count), .instret_count(instret_count)
    );

    cpu_run_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .trigger(trig2), .step_mode(1'b0),
        .bp_en(1'b0), .bp_addr(32'h0), .pc(32'h0), .instr(ADDI),
        .cpu_en(cpu_en2), .cpu_rst_req(cpu_rst_req2), .state(state2),
        .halt_cause(halt_cause2), .cycle_count(cycle2), .instret_count(instret2)
    );

    assign instr = imem[pc_m[7:2]];

    // Core model: PC held at 0 under reset request, advances by 4 when enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_m <= 32'h0;
        end else if (cpu_rst_req) begin
            pc_m <= 32'h0;
        end else if (cpu_en) begin
            pc_m <= pc_m + 32'd4;
        end
    end

    // Count IDLE->RUN transitions and enabled cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (prev_st == 2'd0 && state == 2'd1) run_starts <= run_starts + 1;
        if (cpu_en) en_cnt <= en_cnt + 1;
        prev_st <= state;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_prog(input int halt_at);
        for (int i = 0; i < 64; i++) imem[i] = (i == halt_at) ? HALT : ADDI;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic pulse_trig();
        @(posedge clk); #1 trigger = 1'b1;
        @(posedge clk); @(posedge clk); #1 trigger = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] exp, input int budget, input string tag);
        for (int i = 0; i < budget && state !== exp; i++) @(negedge clk);
        check_eq(tag, 32'(state), 32'(exp));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        load_prog(5);
        @(negedge clk);
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_cause", 32'(halt_cause), 32'd0);
        check_eq("rst_cpu_en", 32'(cpu_en), 32'd0);
        check_eq("rst_req", 32'(cpu_rst_req), 32'd1);
        check_eq("rst_instret", instret_count, 32'd0);
        check_eq("rst_cycle", cycle_count, 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Five addi then halt; exact trigger latency.
        @(posedge clk); #1 trigger = 1'b1;
        @(posedge clk); @(posedge clk); #1 trigger = 1'b0;
        @(posedge clk); @(negedge clk);
        check_eq("lat_req_p3", 32'(cpu_rst_req), 32'd1);
        @(negedge clk);
        check_eq("lat_req_p4", 32'(cpu_rst_req), 32'd0);
        check_eq("run_state", 32'(state), 32'd1);
        check_eq("run_en", 32'(cpu_en), 32'd1);
        repeat (5) @(negedge clk);
        check_eq("halt_pc", pc_m, 32'd20);
        check_eq("halt_en", 32'(cpu_en), 32'd0);
        check_eq("halt_instret_pre", instret_count, 32'd5);
        @(negedge clk);
        check_eq("halt_state", 32'(state), 32'd3);
        check_eq("halt_cause", 32'(halt_cause), 32'd1);
        check_eq("halt_instret", instret_count, 32'd5);
        check_eq("halt_cycles", cycle_count, 32'd6);

        // Restart after halt instruction.
        pulse_trig();
        wait_state(2'd0, 10, "restart_idle");
        check_eq("restart_req", 32'(cpu_rst_req), 32'd1);
        check_eq("idle_hold_instret", instret_count, 32'd5);
        pulse_trig();
        wait_state(2'd1, 10, "restart_run");
        check_eq("restart_instret0", instret_count, 32'd0);
        check_eq("restart_cycle0", cycle_count, 32'd0);
        wait_state(2'd3, 20, "restart_halt");
        check_eq("restart_instret5", instret_count, 32'd5);

        // Breakpoint at 0x0C and resume past it.
        do_reset();
        load_prog(6);
        bp_en = 1'b1; bp_addr = 32'h0000000C;
        pulse_trig();
        wait_state(2'd3, 30, "bp_halt");
        check_eq("bp_cause", 32'(halt_cause), 32'd2);
        check_eq("bp_pc", pc_m, 32'h0000000C);
        check_eq("bp_instret", instret_count, 32'd3);
        check_eq("bp_en_off", 32'(cpu_en), 32'd0);
        pulse_trig();
        wait_state(2'd1, 10, "bp_resume");
        check_eq("bp_resume_pc", pc_m, 32'h0000000C);
        check_eq("bp_resume_en", 32'(cpu_en), 32'd1);
        check_eq("bp_resume_cause", 32'(halt_cause), 32'd0);
        @(negedge clk);
        check_eq("bp_resume_instret", instret_count, 32'd4);
        check_eq("bp_resume_pc2", pc_m, 32'h00000010);
        wait_state(2'd3, 30, "bp_end_halt");
        check_eq("bp_end_cause", 32'(halt_cause), 32'd1);
        check_eq("bp_end_instret", instret_count, 32'd6);
        bp_en = 1'b0;

        // Single step three times.
        do_reset();
        step_mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            base = en_cnt;
            pulse_trig();
            repeat (6) @(negedge clk);
            check_eq("step_state", 32'(state), 32'd3);
            check_eq("step_cause", 32'(halt_cause), 32'd3);
            check_eq("step_instret", instret_count, 32'(k + 1));
            check_eq("step_en_cycles", 32'(en_cnt - base), 32'd1);
        end
        step_mode = 1'b0;

        // Held trigger yields one start; glitch in RUN is ignored.
        do_reset();
        load_prog(40);
        base = run_starts;
        @(posedge clk); #1 trigger = 1'b1;
        repeat (100) @(posedge clk);
        #1 trigger = 1'b0;
        @(negedge clk);
        check_eq("held_starts", 32'(run_starts - base), 32'd1);
        check_eq("held_state", 32'(state), 32'd3);
        check_eq("held_instret", instret_count, 32'd40);
        pulse_trig();
        wait_state(2'd0, 10, "glitch_idle");
        pulse_trig();
        wait_state(2'd1, 10, "glitch_run");
        @(posedge clk); #1 trigger = 1'b1;
        @(posedge clk); #1 trigger = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("glitch_state", 32'(state), 32'd1);
        check_eq("glitch_cause", 32'(halt_cause), 32'd0);
        check_eq("glitch_starts", 32'(run_starts - base), 32'd2);
        wait_state(2'd3, 60, "glitch_end");

        // 4-bit counters saturate; async reset drops cpu_en without a clock.
        @(posedge clk); #1 trig2 = 1'b1;
        @(posedge clk); @(posedge clk); #1 trig2 = 1'b0;
        repeat (25) @(negedge clk);
        check_eq("sat_state", 32'(state2), 32'd1);
        check_eq("sat_instret", 32'(instret2), 32'd15);
        check_eq("sat_cycle", 32'(cycle2), 32'd15);
        repeat (5) @(negedge clk);
        check_eq("sat_instret_hold", 32'(instret2), 32'd15);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        check_eq("async_en", 32'(cpu_en2), 32'd0);
        check_eq("async_state", 32'(state2), 32'd0);
        check_eq("async_req", 32'(cpu_rst_req2), 32'd1);
        check_eq("async_instret", 32'(instret2), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step/halt sequencer for the single-cycle RV32I core. Turns the board `trigger` input into a clean start, step or resume event. Gates core execution through a clock-enable (`cpu_en`) and holds the core in reset while idle. Stops the core on a halt instruction, a PC breakpoint, or single-step completion, and keeps cycle and retired-instruction counters for the testbench and the Vbuddy display.

Parameters:
HALT_INSTR, 32'h0000006F, encoding treated as end-of-program (jal x0,0 self-loop)
CNT_W, 32, width of cycle and instret counters
SYNC_STAGES, 2, trigger synchroniser depth (minimum 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset (0 = reset)
trigger  in  1  raw asynchronous start/resume button
step_mode  in  1  1 = trigger advances one instruction; sampled on trigger edge
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint PC (compared on all 32 bits)
pc  in  32  current core PC
instr  in  32  instruction at pc (core fetch output)
cpu_en  out  1  core state-update enable (PC, regfile, data mem write)
cpu_rst_req  out  1  active-high reset request to core/datapath
state  out  2  0 IDLE, 1 RUN, 2 STEP, 3 HALT
halt_cause  out  2  0 none, 1 HALT_INSTR, 2 breakpoint, 3 step done
cycle_count  out  CNT_W  cycles spent in RUN or STEP
instret_count  out  CNT_W  cycles with cpu_en=1

Behaviour:
- Reset (rst=0, async): state=IDLE, halt_cause=0, counters=0, bp_skip=0, sync flops=0. Outputs: cpu_en=0, cpu_rst_req=1.
- Trigger path: SYNC_STAGES-flop synchroniser, then rising-edge detect. trig_evt is a 1-cycle pulse, latency SYNC_STAGES+1 cycles from the raw edge. Holding trigger high generates exactly one event.
- cpu_rst_req = (state==IDLE). Registered-state decode only, no combinational path from inputs.
- halt_hit = (instr==HALT_INSTR). bp_hit = bp_en & (pc==bp_addr) & ~bp_skip.
- cpu_en = (state==RUN | state==STEP) & ~halt_hit & ~bp_hit. This path is combinational: the halting instruction is never executed.
- IDLE: on trig_evt, clear both counters and halt_cause. Go to STEP if step_mode else RUN.
- RUN: if halt_hit, go HALT with cause 1 (halt_hit wins when both hit). Else if bp_hit, go HALT with cause 2. Else stay.
- STEP:
  - halt_hit → HALT cause 1; bp_hit → HALT cause 2.
  - Otherwise execute exactly one instruction (cpu_en=1 for one cycle), then go HALT cause 3.
- HALT: cpu_en=0. On trig_evt:
  - cause 1 → IDLE (program restart via cpu_rst_req).
  - cause 2 or 3 → RUN, or STEP if step_mode. Set bp_skip=1 and clear halt_cause.
- bp_skip: cleared on the first cycle with cpu_en=1. Lets execution move past the breakpoint PC on resume. Also cleared on entering IDLE.
- trig_evt in RUN or STEP is ignored.
- Counters:
  - cycle_count increments every cycle with state∈{RUN,STEP}.
  - instret_count increments when cpu_en=1.
  - Both saturate at all-ones (no wrap). Both hold value in HALT and IDLE until the next IDLE→RUN/STEP transition.
- Reset mid-RUN: immediate IDLE, cpu_en deasserts asynchronously with rst.
- pc/instr are assumed stable within the cycle. X on instr while cpu_rst_req=1 is don't-care.

Test Plan:
- Reset then pulse trigger (step_mode=0); program of 5 addi then 0x0000006F → cpu_rst_req falls SYNC_STAGES+2 cycles after the edge. instret_count=5, state=HALT, halt_cause=1, cpu_en=0 on the halt instruction cycle.
- bp_en=1, bp_addr=0x0000000C, sequential program from 0 → HALT cause 2 with pc=0x0C and instret=3. Second trigger resumes: instruction at 0x0C executes, instret=4 on the next cycle, no re-halt at 0x0C.
- step_mode=1, three trigger pulses → instret goes 1,2,3. Each pulse gives exactly one cpu_en-high cycle, halt_cause=3 after each.
- trigger held high for 100 cycles in IDLE → exactly one IDLE→RUN transition. Glitch pulses during RUN leave the state unchanged.
- Halted with cause 1, pulse trigger → IDLE, cpu_rst_req=1. Next trigger restarts with counters cleared to 0.
- Force CNT_W=4 with a long loop → instret_count saturates at 15 and does not wrap. Assert rst=0 mid-RUN → cpu_en=0 and state=IDLE in the same cycle, without waiting for clk.
